// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory access unit: FSM state encodings.
package mem_access_unit_pkg;

   localparam int MA_STATE_W = 3;

   typedef enum logic [MA_STATE_W-1:0] {
      MA_IDLE  = 3'd0,
      MA_REQ   = 3'd1,
      MA_WAIT  = 3'd2,
      MA_DONE  = 3'd3,
      MA_ERROR = 3'd4
   } ma_state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Valid/ready request channel plus response channel between the unit and unified memory.
interface mem_access_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/mem_access_unit_wait_timer.sv
// Clear/enable cycle counter bounding how long one transaction may spend in REQ+WAIT.
module wait_timer #(
   parameter int MAX_WAIT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);
   localparam int            CW   = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);
   localparam logic [CW-1:0] TOP  = CW'(MAX_WAIT);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en && (r_count != TOP)) begin
         r_count <= r_count + CW'(1);
      end
   end

   // Flags the cycle whose increment would bring the count to MAX_WAIT.
   assign o_expired = (r_count == LAST);
endmodule

// File: rtl/mem_access_unit.sv
// Bridges the multicycle control FSM's level requests to a valid/ready memory port; owns IR and MDR.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              i_or_d,
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] alu_out,
   input  logic [DATA_W-1:0] write_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] inst_reg,
   output logic [DATA_W-1:0] mdr,
   output logic              error,
   mem_access_unit_if.master mem
);
   ma_state_e         r_state;
   ma_state_e         w_next;
   logic              r_we;
   logic              r_dest;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_ir;
   logic [DATA_W-1:0] r_mdr;
   logic              w_capture;
   logic              w_ld_ir;
   logic              w_ld_mdr;
   logic              w_tmr_clr;
   logic              w_tmr_en;
   logic              w_expired;

   wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
      .clk       (clk),
      .reset     (reset),
      .i_clr     (w_tmr_clr),
      .i_en      (w_tmr_en),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk) begin
      if (!reset) r_state <= MA_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      w_ld_ir   = 1'b0;
      w_ld_mdr  = 1'b0;
      w_tmr_clr = 1'b0;
      w_tmr_en  = 1'b0;
      case (r_state)
         MA_IDLE: begin
            if (mem_read && mem_write) begin
               w_next = MA_ERROR;
            end else if (mem_read ^ mem_write) begin
               w_next    = MA_REQ;
               w_capture = 1'b1;
               w_tmr_clr = 1'b1;
            end
         end
         // The timeout budget covers REQ and WAIT together, so it wins over a late handshake.
         MA_REQ: begin
            w_tmr_en = 1'b1;
            if (w_expired)          w_next = MA_ERROR;
            else if (mem.req_ready) w_next = MA_WAIT;
         end
         MA_WAIT: begin
            w_tmr_en = 1'b1;
            if (mem.rsp_valid) begin
               w_next   = MA_DONE;
               w_ld_ir  = !r_we && !r_dest;
               w_ld_mdr = !r_we &&  r_dest;
            end else if (w_expired) begin
               w_next = MA_ERROR;
            end
         end
         MA_DONE:  w_next = MA_IDLE;
         MA_ERROR: w_next = MA_ERROR;
         default:  w_next = MA_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_we    <= 1'b0;
         r_dest  <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_ir    <= '0;
         r_mdr   <= '0;
      end else begin
         if (w_capture) begin
            r_we    <= mem_write;
            r_dest  <= i_or_d;
            r_addr  <= i_or_d ? alu_out : pc;
            r_wdata <= write_data;
         end
         if (w_ld_ir)  r_ir  <= mem.rsp_data;
         if (w_ld_mdr) r_mdr <= mem.rsp_data;
      end
   end

   assign mem.req_valid = (r_state == MA_REQ);
   assign mem.req_we    = r_we;
   assign mem.req_addr  = r_addr;
   assign mem.req_wdata = r_wdata;

   assign inst_reg = r_ir;
   assign mdr      = r_mdr;
   assign done     = (r_state == MA_DONE);
   assign error    = (r_state == MA_ERROR);

   // A pending request stalls the control FSM in the very cycle it is raised.
   always_comb begin
      case (r_state)
         MA_IDLE:                     busy = mem_read | mem_write;
         MA_REQ, MA_WAIT, MA_ERROR:   busy = 1'b1;
         default:                     busy = 1'b0;
      endcase
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: fetch, load, store, timeout, illegal request, reset abort.
module tb_mem_access_unit;
   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk;
   logic          reset;
   logic          mem_read;
   logic          mem_write;
   logic          i_or_d;
   logic [AW-1:0] pc;
   logic [AW-1:0] alu_out;
   logic [DW-1:0] write_data;
   logic          busy;
   logic          done;
   logic [DW-1:0] inst_reg;
   logic [DW-1:0] mdr;
   logic          error;

   int n_err = 0;
   int n_chk = 0;

   mem_access_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .i_or_d     (i_or_d),
      .pc         (pc),
      .alu_out    (alu_out),
      .write_data (write_data),
      .busy       (busy),
      .done       (done),
      .inst_reg   (inst_reg),
      .mdr        (mdr),
      .error      (error),
      .mem        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0; i_or_d = 1'b0;
      pc = '0; alu_out = '0; write_data = '0;
      bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = '0;
      tick(); tick();
      chk("rst_req_valid", bus.req_valid, 0);
      chk("rst_req_we",    bus.req_we,    0);
      chk("rst_req_addr",  bus.req_addr,  0);
      chk("rst_req_wdata", bus.req_wdata, 0);
      chk("rst_inst_reg",  inst_reg,      0);
      chk("rst_mdr",       mdr,           0);
      chk("rst_error",     error,         0);
      chk("rst_done",      done,          0);
      chk("rst_busy",      busy,          0);
      reset = 1'b1;
      tick();

      // Fetch, zero-wait memory
      pc = 32'h0000_0010; i_or_d = 1'b0; mem_read = 1'b1; bus.req_ready = 1'b1;
      #1 chk("f_busy_c0", busy, 1);
      tick();
      chk("f_req_valid_c1", bus.req_valid, 1);
      chk("f_req_addr_c1",  bus.req_addr,  32'h10);
      chk("f_req_we_c1",    bus.req_we,    0);
      tick();
      chk("f_req_valid_c2", bus.req_valid, 0);
      chk("f_done_c2",      done,          0);
      bus.rsp_valid = 1'b1; bus.rsp_data = 32'h0000_0093;
      tick();
      chk("f_done_c3",  done,     1);
      chk("f_ir_c3",    inst_reg, 32'h93);
      chk("f_mdr_c3",   mdr,      0);
      chk("f_busy_c3",  busy,     0);
      mem_read = 1'b0; bus.rsp_valid = 1'b0;
      tick();
      chk("f_done_c4", done,     0);
      chk("f_ir_c4",   inst_reg, 32'h93);

      // Load with 4 cycles of backpressure, response 2 cycles after handshake
      alu_out = 32'h100; i_or_d = 1'b1; mem_read = 1'b1; bus.req_ready = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("l_req_valid_bp", bus.req_valid, 1);
         chk("l_req_addr_bp",  bus.req_addr,  32'h100);
         chk("l_busy_bp",      busy,          1);
         tick();
      end
      bus.req_ready = 1'b1;
      chk("l_req_valid_hs", bus.req_valid, 1);
      chk("l_req_addr_hs",  bus.req_addr,  32'h100);
      tick();
      bus.req_ready = 1'b0;
      chk("l_req_valid_w1", bus.req_valid, 0);
      chk("l_busy_w1",      busy,          1);
      tick();
      chk("l_busy_w2", busy, 1);
      chk("l_done_w2", done, 0);
      bus.rsp_valid = 1'b1; bus.rsp_data = 32'hDEAD_BEEF;
      tick();
      chk("l_done", done,     1);
      chk("l_mdr",  mdr,      32'hDEAD_BEEF);
      chk("l_ir",   inst_reg, 32'h93);
      mem_read = 1'b0; bus.rsp_valid = 1'b0;
      tick();
      chk("l_done_after", done, 0);

      // Store
      alu_out = 32'h200; write_data = 32'h1234_5678; mem_write = 1'b1; bus.req_ready = 1'b1;
      tick();
      chk("s_req_valid", bus.req_valid, 1);
      chk("s_req_we",    bus.req_we,    1);
      chk("s_req_addr",  bus.req_addr,  32'h200);
      chk("s_req_wdata", bus.req_wdata, 32'h1234_5678);
      tick();
      bus.rsp_valid = 1'b1; bus.rsp_data = 32'hFFFF_0000;
      tick();
      chk("s_done", done,     1);
      chk("s_mdr",  mdr,      32'hDEAD_BEEF);
      chk("s_ir",   inst_reg, 32'h93);
      mem_write = 1'b0; bus.rsp_valid = 1'b0;
      tick();
      chk("s_done_once", done, 0);
      chk("s_mdr_hold",  mdr,  32'hDEAD_BEEF);

      // Timeout: req_ready stuck low, MAX_WAIT = 8
      pc = 32'h40; i_or_d = 1'b0; mem_read = 1'b1; bus.req_ready = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) begin
         chk("t_req_valid", bus.req_valid, 1);
         chk("t_no_error",  error,         0);
         tick();
      end
      chk("t_error",     error,         1);
      chk("t_req_valid_drop", bus.req_valid, 0);
      chk("t_busy",      busy,          1);
      mem_read = 1'b0;
      tick();
      chk("t_error_sticky", error,    1);
      chk("t_ir_hold",      inst_reg, 32'h93);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("t_rst_error", error,    0);
      chk("t_rst_ir",    inst_reg, 0);
      chk("t_rst_mdr",   mdr,      0);

      // Illegal request
      mem_read = 1'b1; mem_write = 1'b1; bus.req_ready = 1'b1;
      #1 chk("i_busy_idle", busy, 1);
      tick();
      mem_read = 1'b0; mem_write = 1'b0;
      chk("i_error", error, 1);
      chk("i_busy",  busy,  1);
      for (int i = 0; i < 3; i++) begin
         bus.rsp_valid = 1'b1; bus.rsp_data = 32'hAAAA_5555;
         tick();
         chk("i_error_hold", error,         1);
         chk("i_busy_hold",  busy,          1);
         chk("i_no_req",     bus.req_valid, 0);
         chk("i_ir_hold",    inst_reg,      0);
      end
      bus.rsp_valid = 1'b0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("i_rst_error", error, 0);
      chk("i_rst_busy",  busy,  0);

      // Reset mid-WAIT, then a stale response
      pc = 32'h80; i_or_d = 1'b0; mem_read = 1'b1; bus.req_ready = 1'b1;
      tick();
      tick();
      chk("r_in_wait", bus.req_valid, 0);
      reset = 1'b0;
      tick();
      reset = 1'b1; mem_read = 1'b0;
      bus.rsp_valid = 1'b1; bus.rsp_data = 32'hFFFF_FFFF;
      chk("r_done_rst", done, 0);
      tick();
      chk("r_ir",    inst_reg, 0);
      chk("r_mdr",   mdr,      0);
      chk("r_done",  done,     0);
      chk("r_busy",  busy,     0);
      chk("r_error", error,    0);
      bus.rsp_valid = 1'b0;
      tick();
      chk("r_done_later", done,     0);
      chk("r_ir_later",   inst_reg, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
